ioctl_download_streamer: RTL and testbench
==========================================

// Module: ioctl_download_streamer
// PURPOSE
//  Drives the HPS-style ioctl download interface (download/wr/addr/dout/index, honouring wait) into the core.
//  Bytes come from a valid/ready byte stream, such as a ROM image in the sim harness or an on-chip loader.
//  One start command sends start_len bytes under a single index, with a programmable strobe spacing.
//  Sits upstream of the emu top; its ioctl_* outputs connect directly to the core's ioctl_* inputs.
// PARAMETERS
//  ADDR_W     25  width of ioctl_addr and start_len
//  SETUP_CYC  2   cycles ioctl_download is held high before the first strobe (min 1)
//  TAIL_CYC   2   cycles ioctl_download is held high after the last strobe (min 1)
//  WR_GAP     4   idle cycles after each ioctl_wr pulse before the next byte is fetched (min 1)
// PORTS
//  clk_sys         in   1       system clock; all logic on its rising edge
//  reset_n         in   1       asynchronous active-low reset
//  start           in   1       1-cycle command pulse; accepted only in IDLE
//  start_index     in   8       latched into ioctl_index on accept
//  start_len       in   ADDR_W  byte count; 0 is legal
//  abort           in   1       cancel the transfer in progress
//  busy            out  1       high from the cycle after accept until the return to IDLE
//  done            out  1       1-cycle pulse when a transfer completes normally (not on abort)
//  s_data          in   8       stream byte
//  s_valid         in   1       stream byte valid
//  s_ready         out  1       high only in FETCH; a byte transfers when s_valid & s_ready
//  ioctl_download  out  1       download window
//  ioctl_wr        out  1       single-cycle write strobe
//  ioctl_addr      out  ADDR_W  byte offset within the transfer
//  ioctl_dout      out  8       write data
//  ioctl_index     out  8       transfer index
//  ioctl_wait      in   1       core back-pressure; blocks the strobe while high
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; all outputs 0; counters 0. Reset mid-transfer drops ioctl_download at once.
//  All outputs are registered.
//  States: IDLE, SETUP, FETCH, WAITW, STROBE, GAP, TAIL.
//   IDLE:   start=1 -> SETUP. Latch index and len; ioctl_addr<=0; set ioctl_download=1 and busy=1 on the next edge.
//   SETUP:  lasts SETUP_CYC cycles. Then -> FETCH if len!=0, else -> TAIL.
//   FETCH:  s_ready=1. On s_valid: ioctl_dout<=s_data, -> WAITW. Stays in FETCH indefinitely while s_valid=0.
//   WAITW:  -> STROBE when ioctl_wait=0. Otherwise hold, with addr and dout stable.
//   STROBE: ioctl_wr=1 for exactly this one cycle; addr and dout stable.
//           Exit edge: ioctl_addr+=1, remaining-=1, -> GAP.
//   GAP:    WR_GAP cycles; ioctl_wait high extends GAP. Then -> FETCH if remaining!=0, else -> TAIL.
//   TAIL:   TAIL_CYC cycles. Final edge: ioctl_download<=0, busy<=0, done<=1 for 1 cycle, -> IDLE.
//  Steady spacing: with s_valid=1 and ioctl_wait=0, consecutive wr pulses are exactly WR_GAP+3 cycles apart.
//  During each strobe, ioctl_addr equals the 0-based byte number. After completion, ioctl_addr==len. Addr wraps modulo 2^ADDR_W.
//  start while busy: ignored, with no effect on latched values.
//  abort while busy (any state except IDLE): -> IDLE on the next edge.
//   ioctl_download, ioctl_wr, busy and s_ready go to 0; done stays 0.
//   abort has priority over every transition and over a simultaneous strobe.
//  start and abort in the same cycle in IDLE: start wins (abort is a no-op in IDLE).
//  ioctl_index is held after the transfer until the next accept. ioctl_dout holds its last byte.
// TESTING
//  1 Reset asserted mid-STROBE -> ioctl_wr/download/busy/s_ready all 0 asynchronously; after release, IDLE and start accepted.
//  2 start idx=8'h01 len=3, stream AA,BB,CC always valid, wait=0, defaults ->
//    download rises 1 cycle after start; 3 wr pulses at addr 0,1,2 with dout AA,BB,CC, 7 cycles apart;
//    done pulses with download falling; final addr=3.
//  3 ioctl_wait=1 for 10 cycles entering WAITW before byte 1 ->
//    no wr for those 10 cycles; addr=1 and dout=BB stable; strobe 1 cycle after wait falls.
//  4 s_valid=0 for 20 cycles in FETCH -> s_ready held 1, download stays 1, no wr; resumes on valid.
//  5 len=0 -> download high SETUP_CYC+TAIL_CYC cycles; zero wr; done pulses once.
//  6 abort in GAP after byte 0 (len=4); start re-issued while busy ->
//    second start ignored; download 0 next cycle; done never pulses; next start restarts at addr 0.

Source files
------------

// File: rtl/ioctl_download_streamer.sv
// ioctl_download_streamer
// Streams a byte source into the HPS-style ioctl download port of the core.
// One start command sends start_len bytes under one index, with fixed
// setup/tail windows around the transfer and a programmable strobe gap.
module ioctl_download_streamer #(
  parameter int ADDR_W    = 25,
  parameter int SETUP_CYC = 2,
  parameter int TAIL_CYC  = 2,
  parameter int WR_GAP    = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        start_index,
  input  logic [ADDR_W-1:0] start_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ioctl_download,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_index,
  input  logic              ioctl_wait
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_WAITW  = 3'd3;
  localparam logic [2:0] S_STROBE = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;
  localparam logic [2:0] S_TAIL   = 3'd6;

  localparam int CNT_MAX = (SETUP_CYC > TAIL_CYC)
                         ? ((SETUP_CYC > WR_GAP) ? SETUP_CYC : WR_GAP)
                         : ((TAIL_CYC  > WR_GAP) ? TAIL_CYC  : WR_GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] TAIL_LOAD  = CNT_W'(TAIL_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(WR_GAP - 1);

  logic [2:0]        state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [ADDR_W-1:0] rem_q,      rem_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [7:0]        dout_q,     dout_d;
  logic [7:0]        index_q,    index_d;
  logic              download_q, download_d;
  logic              wr_q,       wr_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              s_ready_q,  s_ready_d;

  // Next-state logic; every output is computed one cycle ahead so it can be registered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    index_d    = index_q;
    download_d = download_q;
    busy_d     = busy_q;
    s_ready_d  = s_ready_q;
    wr_d       = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SETUP;
          index_d    = start_index;
          rem_d      = start_len;
          addr_d     = '0;
          cnt_d      = SETUP_LOAD;
          download_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          if (rem_q != '0) begin
            state_d   = S_FETCH;
            s_ready_d = 1'b1;
          end else begin
            state_d = S_TAIL;
            cnt_d   = TAIL_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FETCH: begin
        if (s_valid && s_ready_q) begin
          dout_d    = s_data;
          s_ready_d = 1'b0;
          state_d   = S_WAITW;
        end
      end
      S_WAITW: begin
        if (!ioctl_wait) begin
          state_d = S_STROBE;
          wr_d    = 1'b1;
        end
      end
      S_STROBE: begin
        addr_d  = addr_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        cnt_d   = GAP_LOAD;
        state_d = S_GAP;
      end
      S_GAP: begin
        // Core back-pressure freezes the gap count rather than just blocking the exit.
        if (!ioctl_wait) begin
          if (cnt_q == '0) begin
            if (rem_q != '0) begin
              state_d   = S_FETCH;
              s_ready_d = 1'b1;
            end else begin
              state_d = S_TAIL;
              cnt_d   = TAIL_LOAD;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_TAIL: begin
        if (cnt_q == '0) begin
          state_d    = S_IDLE;
          download_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        download_d = 1'b0;
        busy_d     = 1'b0;
        s_ready_d  = 1'b0;
      end
    endcase

    // Abort overrides every transition above, including a strobe about to issue.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      download_d = 1'b0;
      wr_d       = 1'b0;
      busy_d     = 1'b0;
      s_ready_d  = 1'b0;
      done_d     = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      index_q    <= '0;
      download_q <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      index_q    <= index_d;
      download_q <= download_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      s_ready_q  <= s_ready_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign s_ready        = s_ready_q;
  assign ioctl_download = download_q;
  assign ioctl_wr       = wr_q;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign ioctl_index    = index_q;

endmodule

// File: tb/tb_ioctl_download_streamer.sv
// Directed bench for ioctl_download_streamer: hand-computed cycle positions
// of download/wr/done relative to the start cycle N.
module tb_ioctl_download_streamer;

  localparam int ADDR_W = 25;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        start_index = '0;
  logic [ADDR_W-1:0] start_len = '0;
  logic              abort = 1'b0;
  logic              busy, done;
  logic [7:0]        s_data;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              ioctl_download, ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout, ioctl_index;
  logic              ioctl_wait = 1'b0;

  int unsigned total = 0;
  int unsigned bad   = 0;

  ioctl_download_streamer #(
    .ADDR_W(ADDR_W), .SETUP_CYC(2), .TAIL_CYC(2), .WR_GAP(4)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .start_index(start_index),
    .start_len(start_len), .abort(abort), .busy(busy), .done(done),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait)
  );

  always #5 clk_sys = ~clk_sys;

  // Cycle counter: value seen after a rising edge names that cycle.
  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Byte source.
  logic       clr = 1'b0;
  logic [7:0] sbytes [8];
  logic [2:0] sidx = '0;
  assign s_data = sbytes[sidx];
  always @(posedge clk_sys) begin
    if (clr) sidx <= '0;
    else if (s_valid && s_ready) sidx <= sidx + 1'b1;
  end

  // Output monitor, sampled on the falling edge.
  logic [31:0] wr_cyc[$], wr_addr[$], wr_dat[$];
  int unsigned done_cnt = 0, done_cyc = 0, dl_cnt = 0, dl_rise = 0;
  logic        done_dl = 1'b0, dl_prev = 1'b0;
  always @(negedge clk_sys) begin
    if (clr) begin
      wr_cyc.delete(); wr_addr.delete(); wr_dat.delete();
      done_cnt <= 0; done_cyc <= 0; dl_cnt <= 0; dl_rise <= 0; done_dl <= 1'b0;
    end else begin
      if (ioctl_wr) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(32'(ioctl_addr));
        wr_dat.push_back(32'(ioctl_dout));
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
        done_dl  <= ioctl_download;
      end
      if (ioctl_download) dl_cnt <= dl_cnt + 1;
      if (ioctl_download && !dl_prev) dl_rise <= cyc;
    end
    dl_prev <= ioctl_download;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic clr_all();
    clr = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    #1 clr = 1'b0;
  endtask

  task automatic goto_cyc(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Start is high during cycle n; accepted on the edge into n+1.
  task automatic do_start(input logic [7:0] idx, input logic [ADDR_W-1:0] len,
                          output int unsigned n);
    @(posedge clk_sys);
    #1;
    start = 1'b1; start_index = idx; start_len = len;
    n = cyc;
    @(posedge clk_sys);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_sys);
      if (!busy) break;
    end
    check(tag, 32'(busy), 32'd0);
    @(negedge clk_sys);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    logic        stable;

    // Reset state
    repeat (3) @(negedge clk_sys);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_ready", 32'(s_ready), 0);
    check("rst_dl",    32'(ioctl_download), 0);
    check("rst_wr",    32'(ioctl_wr), 0);
    check("rst_addr",  32'(ioctl_addr), 0);
    check("rst_dout",  32'(ioctl_dout), 0);
    check("rst_index", 32'(ioctl_index), 0);
    reset_n = 1'b1;

    // 1: reset asserted during a strobe
    sbytes[0] = 8'hAA; sbytes[1] = 8'hBB; sbytes[2] = 8'hCC;
    clr_all();
    s_valid = 1'b1;
    do_start(8'h01, 3, n);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_sys);
      if (ioctl_wr) break;
    end
    check("t1_wr_seen", 32'(ioctl_wr), 1);
    #1 reset_n = 1'b0;
    #1;
    check("t1_wr",    32'(ioctl_wr), 0);
    check("t1_dl",    32'(ioctl_download), 0);
    check("t1_busy",  32'(busy), 0);
    check("t1_ready", 32'(s_ready), 0);
    @(negedge clk_sys) reset_n = 1'b1;
    @(negedge clk_sys);
    check("t1_idle_busy", 32'(busy), 0);

    // 2: basic 3-byte transfer
    clr_all();
    do_start(8'h01, 3, n);
    wait_idle("t2_timeout");
    check("t2_dl_rise", dl_rise, n + 1);
    check("t2_nwr",     wr_cyc.size(), 3);
    check("t2_wr0_cyc", qget(wr_cyc, 0), n + 5);
    check("t2_space01", qget(wr_cyc, 1) - qget(wr_cyc, 0), 7);
    check("t2_space12", qget(wr_cyc, 2) - qget(wr_cyc, 1), 7);
    check("t2_addr0",   qget(wr_addr, 0), 0);
    check("t2_addr1",   qget(wr_addr, 1), 1);
    check("t2_addr2",   qget(wr_addr, 2), 2);
    check("t2_dat0",    qget(wr_dat, 0), 32'hAA);
    check("t2_dat1",    qget(wr_dat, 1), 32'hBB);
    check("t2_dat2",    qget(wr_dat, 2), 32'hCC);
    check("t2_ndone",   done_cnt, 1);
    check("t2_done_cyc", done_cyc, n + 26);
    check("t2_done_dl", 32'(done_dl), 0);
    check("t2_dl_cnt",  dl_cnt, 25);
    check("t2_addr_end", 32'(ioctl_addr), 3);
    check("t2_index",   32'(ioctl_index), 32'h01);
    check("t2_dout_hold", 32'(ioctl_dout), 32'hCC);

    // 3: core wait held for 10 cycles in WAITW before byte 1
    clr_all();
    do_start(8'h02, 3, n);
    goto_cyc(n + 11);
    ioctl_wait = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk_sys);
      stable &= (ioctl_addr == 1) && (ioctl_dout == 8'hBB) && !ioctl_wr && ioctl_download;
    end
    goto_cyc(n + 21);
    ioctl_wait = 1'b0;
    wait_idle("t3_timeout");
    check("t3_stable",  32'(stable), 1);
    check("t3_nwr",     wr_cyc.size(), 3);
    check("t3_wr1_cyc", qget(wr_cyc, 1), n + 22);
    check("t3_wr2_cyc", qget(wr_cyc, 2), n + 29);
    check("t3_addr1",   qget(wr_addr, 1), 1);
    check("t3_dat1",    qget(wr_dat, 1), 32'hBB);
    check("t3_index",   32'(ioctl_index), 32'h02);

    // 4: stream stalls for 20 cycles in FETCH
    sbytes[0] = 8'h11; sbytes[1] = 8'h22;
    clr_all();
    s_valid = 1'b0;
    do_start(8'h03, 2, n);
    goto_cyc(n + 3);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk_sys);
      stable &= s_ready && ioctl_download && !ioctl_wr;
    end
    goto_cyc(n + 23);
    s_valid = 1'b1;
    wait_idle("t4_timeout");
    check("t4_stall",   32'(stable), 1);
    check("t4_nwr",     wr_cyc.size(), 2);
    check("t4_wr0_cyc", qget(wr_cyc, 0), n + 25);
    check("t4_wr1_cyc", qget(wr_cyc, 1), n + 32);
    check("t4_dat0",    qget(wr_dat, 0), 32'h11);
    check("t4_dat1",    qget(wr_dat, 1), 32'h22);
    check("t4_ndone",   done_cnt, 1);

    // 5: zero-length transfer
    clr_all();
    do_start(8'h04, 0, n);
    wait_idle("t5_timeout");
    check("t5_dl_rise",  dl_rise, n + 1);
    check("t5_dl_cnt",   dl_cnt, 4);
    check("t5_nwr",      wr_cyc.size(), 0);
    check("t5_ndone",    done_cnt, 1);
    check("t5_done_cyc", done_cyc, n + 5);
    check("t5_addr",     32'(ioctl_addr), 0);

    // 6: abort in GAP after byte 0, with a second start while busy
    sbytes[0] = 8'h5A; sbytes[1] = 8'hA5; sbytes[2] = 8'h3C; sbytes[3] = 8'hC3;
    clr_all();
    do_start(8'h06, 4, n);
    goto_cyc(n + 3);
    start = 1'b1; start_index = 8'h77; start_len = 9;
    goto_cyc(n + 4);
    start = 1'b0;
    goto_cyc(n + 7);
    abort = 1'b1;
    @(negedge clk_sys);
    check("t6_dl_before", 32'(ioctl_download), 1);
    goto_cyc(n + 8);
    abort = 1'b0;
    @(negedge clk_sys);
    check("t6_dl_after",    32'(ioctl_download), 0);
    check("t6_busy_after",  32'(busy), 0);
    check("t6_ready_after", 32'(s_ready), 0);
    check("t6_wr_after",    32'(ioctl_wr), 0);
    repeat (20) @(negedge clk_sys);
    check("t6_ndone", done_cnt, 0);
    check("t6_nwr",   wr_cyc.size(), 1);
    check("t6_index", 32'(ioctl_index), 32'h06);
    check("t6_dl_idle", 32'(ioctl_download), 0);

    clr_all();
    do_start(8'h33, 1, n);
    check("t6_restart_addr", 32'(ioctl_addr), 0);
    wait_idle("t6_timeout");
    check("t6_r_nwr",   wr_cyc.size(), 1);
    check("t6_r_addr0", qget(wr_addr, 0), 0);
    check("t6_r_dat0",  qget(wr_dat, 0), 32'h5A);
    check("t6_r_index", 32'(ioctl_index), 32'h33);
    check("t6_r_ndone", done_cnt, 1);
    check("t6_r_addr_end", 32'(ioctl_addr), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
